// File: rtl/hlr_pkg.sv
// Shared types and Booth digit decoders for the hybrid low-radix Booth multiplier.
package hlr_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_ABE1  = 2'b01,
        MODE_ABE2  = 2'b10
    } hlr_mode_e;

    localparam logic signed [3:0] DIG_0  = 4'sd0;
    localparam logic signed [3:0] DIG_P1 = 4'sd1;
    localparam logic signed [3:0] DIG_P2 = 4'sd2;
    localparam logic signed [3:0] DIG_P3 = 4'sd3;
    localparam logic signed [3:0] DIG_P4 = 4'sd4;
    localparam logic signed [3:0] DIG_N1 = -4'sd1;
    localparam logic signed [3:0] DIG_N2 = -4'sd2;
    localparam logic signed [3:0] DIG_N3 = -4'sd3;
    localparam logic signed [3:0] DIG_N4 = -4'sd4;

    typedef struct packed {
        logic signed [3:0] dig;
        logic              approx;
    } r8_dig_t;

    // The reserved encoding 2'b11 runs as exact.
    function automatic hlr_mode_e eff_mode(input logic [1:0] mode);
        hlr_mode_e m;
        case (mode)
            2'b01:   m = MODE_ABE1;
            2'b10:   m = MODE_ABE2;
            default: m = MODE_EXACT;
        endcase
        return m;
    endfunction

    function automatic r8_dig_t r8_digit(input logic [3:0] code, input hlr_mode_e mode);
        r8_dig_t r;
        r.dig    = DIG_0;
        r.approx = 1'b0;
        case (code)
            4'b0001, 4'b0010: r.dig = DIG_P1;
            4'b0011, 4'b0100: r.dig = DIG_P2;
            4'b0111:          r.dig = DIG_P4;
            4'b1000:          r.dig = DIG_N4;
            4'b1011, 4'b1100: r.dig = DIG_N2;
            4'b1101, 4'b1110: r.dig = DIG_N1;
            4'b0101: begin
                r.dig    = (mode == MODE_EXACT) ? DIG_P3 :
                           (mode == MODE_ABE1)  ? DIG_P4 : DIG_P2;
                r.approx = (mode != MODE_EXACT);
            end
            4'b0110: begin
                r.dig    = (mode == MODE_EXACT) ? DIG_P3 : DIG_P4;
                r.approx = (mode != MODE_EXACT);
            end
            4'b1001: begin
                r.dig    = (mode == MODE_EXACT) ? DIG_N3 : DIG_N4;
                r.approx = (mode != MODE_EXACT);
            end
            4'b1010: begin
                r.dig    = (mode == MODE_EXACT) ? DIG_N3 :
                           (mode == MODE_ABE1)  ? DIG_N4 : DIG_N2;
                r.approx = (mode != MODE_EXACT);
            end
            default: r.dig = DIG_0;
        endcase
        return r;
    endfunction

    function automatic logic signed [2:0] r4_digit(input logic [2:0] code);
        logic signed [2:0] d;
        case (code)
            3'b001, 3'b010: d = 3'sd1;
            3'b011:         d = 3'sd2;
            3'b100:         d = -3'sd2;
            3'b101, 3'b110: d = -3'sd1;
            default:        d = 3'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hlr_pp_gen.sv
// Combinational partial-product generator and adder: radix-8 groups in the LSBs,
// exact radix-4 groups above them, summed modulo 2^(2*WIDTH+1).
module hlr_pp_gen
    import hlr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_R8  = 2
) (
    input  logic [WIDTH:0]     i_x,
    input  logic [WIDTH-1:0]   i_b,
    input  hlr_mode_e          i_mode,
    output logic [2*WIDTH-1:0] o_z,
    output logic               o_approx
);

    localparam int PW   = 2*WIDTH + 1;
    localparam int N_R4 = (WIDTH - 3*N_R8) / 2;

    if (WIDTH < 4 || N_R8 < 0 || 3*N_R8 > WIDTH || ((WIDTH - 3*N_R8) % 2) != 0) begin : g_bad_params
        $error("hlr_pp_gen: WIDTH - 3*N_R8 must be even and non-negative, WIDTH >= 4");
    end

    // Digit magnitudes are at most 4, so a shift-and-add covers every case.
    function automatic logic [PW-1:0] scale(input logic [PW-1:0] b, input logic signed [3:0] d);
        logic [3:0]    mag;
        logic [PW-1:0] m;
        mag = d[3] ? 4'(-d) : 4'(d);
        case (mag)
            4'd1:    m = b;
            4'd2:    m = b << 1;
            4'd3:    m = (b << 1) + b;
            4'd4:    m = b << 2;
            default: m = '0;
        endcase
        return d[3] ? -m : m;
    endfunction

    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     sum;
    logic              approx;
    r8_dig_t           d8;
    logic signed [2:0] d4;

    always_comb begin
        b_ext  = {{(PW-WIDTH){i_b[WIDTH-1]}}, i_b};
        sum    = '0;
        approx = 1'b0;
        d8     = '0;
        d4     = '0;
        for (int k = 0; k < N_R8; k++) begin
            d8     = r8_digit(i_x[3*k +: 4], i_mode);
            sum    = sum + (scale(b_ext, d8.dig) << (3*k));
            approx = approx | d8.approx;
        end
        for (int j = 0; j < N_R4; j++) begin
            d4  = r4_digit(i_x[3*N_R8 + 2*j +: 3]);
            sum = sum + (scale(b_ext, {d4[2], d4}) << (3*N_R8 + 2*j));
        end
    end

    assign o_z      = sum[2*WIDTH-1:0];
    assign o_approx = approx;

endmodule

// File: rtl/hlr_bm_pipe.sv
// Two-stage valid/ready pipeline around the hybrid low-radix Booth multiplier:
// S1 holds operands and effective mode, S2 holds the product and approximation flag.
module hlr_bm_pipe
    import hlr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_R8  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [1:0]         i_mode,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_z,
    output logic               o_approx
);

    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   a1_q, a1_d;
    logic [WIDTH-1:0]   b1_q, b1_d;
    hlr_mode_e          mode1_q, mode1_d;
    logic               v2_q, v2_d;
    logic [2*WIDTH-1:0] z2_q, z2_d;
    logic               apx2_q, apx2_d;

    logic               adv1, adv2, accept;
    logic [2*WIDTH-1:0] pp_z;
    logic               pp_approx;

    hlr_pp_gen #(
        .WIDTH (WIDTH),
        .N_R8  (N_R8)
    ) u_pp_gen (
        .i_x      ({a1_q, 1'b0}),
        .i_b      (b1_q),
        .i_mode   (mode1_q),
        .o_z      (pp_z),
        .o_approx (pp_approx)
    );

    always_comb begin
        adv2    = ~v2_q | i_ready;
        adv1    = ~v1_q | adv2;
        accept  = i_valid & adv1;

        v1_d    = v1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        mode1_d = mode1_q;
        v2_d    = v2_q;
        z2_d    = z2_q;
        apx2_d  = apx2_q;

        if (adv1) begin
            v1_d = i_valid;
        end
        if (accept) begin
            a1_d    = i_a;
            b1_d    = i_b;
            mode1_d = eff_mode(i_mode);
        end
        // S2 data only moves when a real S1 result replaces it, so it holds under stall.
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                z2_d   = pp_z;
                apx2_d = pp_approx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            mode1_q <= MODE_EXACT;
            v2_q    <= 1'b0;
            z2_q    <= '0;
            apx2_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            mode1_q <= mode1_d;
            v2_q    <= v2_d;
            z2_q    <= z2_d;
            apx2_q  <= apx2_d;
        end
    end

    assign o_ready  = adv1;
    assign o_valid  = v2_q;
    assign o_z      = z2_q;
    assign o_approx = apx2_q;

endmodule

// File: tb/tb_hlr_bm_pipe.sv
// Directed and randomized checks of hlr_bm_pipe against a digit-arithmetic reference model.
module tb_hlr_bm_pipe;

    localparam int W   = 8;
    localparam int NR8 = 2;
    localparam int NR4 = (W - 3*NR8) / 2;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic           i_ready = 1'b0;
    logic [W-1:0]   i_a = '0;
    logic [W-1:0]   i_b = '0;
    logic [1:0]     i_mode = '0;
    logic           o_ready;
    logic           o_valid;
    logic [2*W-1:0] o_z;
    logic           o_approx;

    hlr_bm_pipe #(.WIDTH(W), .N_R8(NR8)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_mode   (i_mode),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_z      (o_z),
        .o_approx (o_approx)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Digit value is -4*c3 + 2*c2 + c1 + c0; the approximation rules are then applied
    // to the +-3 digits. Exact modes are held to the true signed product.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                                  output logic [2*W-1:0] z, output logic apx);
        logic [W:0] x;
        logic [3:0] c;
        logic [2:0] c4;
        longint     acc, bv;
        int         d, c0, c1, c2, c3;
        bit         am;
        x   = {a, 1'b0};
        bv  = longint'($signed(b));
        acc = 0;
        apx = 1'b0;
        am  = (m == 2'b01) || (m == 2'b10);
        for (int k = 0; k < NR8; k++) begin
            c  = x[3*k +: 4];
            c0 = int'(c[0]); c1 = int'(c[1]); c2 = int'(c[2]); c3 = int'(c[3]);
            d  = -4*c3 + 2*c2 + c1 + c0;
            if (am && (d == 3 || d == -3)) begin
                apx = 1'b1;
                if (m == 2'b01) d = (d > 0) ? 4 : -4;
                else            d = (c == 4'b0101) ? 2 : (c == 4'b0110) ? 4 : (c == 4'b1010) ? -2 : -4;
            end
            acc += longint'(d) * bv * (longint'(1) << (3*k));
        end
        for (int j = 0; j < NR4; j++) begin
            c4 = x[3*NR8 + 2*j +: 3];
            c0 = int'(c4[0]); c1 = int'(c4[1]); c2 = int'(c4[2]);
            d  = -2*c2 + c1 + c0;
            acc += longint'(d) * bv * (longint'(1) << (3*NR8 + 2*j));
        end
        if (!am) acc = longint'($signed(a)) * bv;
        z = acc[2*W-1:0];
    endfunction

    typedef struct {
        logic [2*W-1:0] z;
        logic           apx;
    } exp_t;

    exp_t           sb_q[$];
    exp_t           e_pop, e_push;
    bit             sb_en = 1'b0;
    int             n_acc = 0;
    logic           prev_stall = 1'b0;
    logic [2*W-1:0] prev_z = '0;
    logic           prev_apx = 1'b0;

    always @(negedge i_clk) begin
        if (sb_en && i_rst_n) begin
            if (prev_stall)
                chk("rand_hold", 64'({o_valid, o_approx, o_z}), 64'({1'b1, prev_apx, prev_z}));
            prev_stall = o_valid & ~i_ready;
            prev_z     = o_z;
            prev_apx   = o_approx;
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    chk("rand_spurious", 64'(o_valid), 64'(0));
                end else begin
                    e_pop = sb_q.pop_front();
                    chk("rand_result", 64'({o_approx, o_z}), 64'({e_pop.apx, e_pop.z}));
                end
            end
            if (i_valid && o_ready) begin
                model(i_a, i_b, i_mode, e_push.z, e_push.apx);
                sb_q.push_back(e_push);
                n_acc++;
            end
        end
    end

    // Called just after a rising edge with an empty pipeline; checks the 2-cycle latency.
    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] m, input logic [2*W-1:0] ez, input logic eapx);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_mode  = m;
        @(negedge i_clk);
        chk({tag, "_rdy"}, 64'(o_ready), 64'(1));
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_a     = ~a;
        i_mode  = ~m;
        @(negedge i_clk);
        chk({tag, "_lat1"}, 64'(o_valid), 64'(0));
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk({tag, "_res"}, 64'({o_valid, o_approx, o_z}), 64'({1'b1, eapx, ez}));
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk({tag, "_drop"}, 64'(o_valid), 64'(0));
        @(posedge i_clk); #1;
    endtask

    logic [W-1:0]   bp_a [4] = '{8'd3, 8'hf9, 8'd100, 8'hce};
    logic [W-1:0]   bp_b [4] = '{8'd4, 8'd11, 8'hfe, 8'hc4};
    logic [2*W-1:0] bp_e [4];
    logic [2*W-1:0] got_q[$];
    logic           dummy_apx;
    int             idx;

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_state", 64'({o_valid, o_approx, o_z}), 64'(0));
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        single("ex_min",    8'h80, 8'h80, 2'b00, 16'h4000, 1'b0);
        single("ex_5x10",   8'd5,  8'd10, 2'b00, 16'd50,   1'b0);
        single("abe2_5x10", 8'd5,  8'd10, 2'b10, 16'd60,   1'b1);
        single("abe2_3x7",  8'd3,  8'd7,  2'b10, 16'd28,   1'b1);
        single("abe2_m1x9", 8'hff, 8'd9,  2'b10, 16'hfff7, 1'b0);
        single("abe1_5x10", 8'd5,  8'd10, 2'b01, 16'd40,   1'b1);
        single("abe1_3x7",  8'd3,  8'd7,  2'b01, 16'd28,   1'b1);
        single("rsv_5x10",  8'd5,  8'd10, 2'b11, 16'd50,   1'b0);

        // Backpressure: i_ready low for the first 5 cycles of a 4-operand stream.
        for (int i = 0; i < 4; i++) model(bp_a[i], bp_b[i], 2'b00, bp_e[i], dummy_apx);
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            i_ready = (cyc >= 5);
            i_valid = (idx < 4);
            i_mode  = 2'b00;
            if (idx < 4) begin
                i_a = bp_a[idx];
                i_b = bp_b[idx];
            end
            @(negedge i_clk);
            if (cyc == 2) chk("bp_ready_low", 64'(o_ready), 64'(0));
            if (cyc == 4) chk("bp_accepts", 64'(idx), 64'(2));
            if (cyc >= 2 && cyc < 5) chk("bp_hold", 64'({o_valid, o_z}), 64'({1'b1, bp_e[0]}));
            if (o_valid && i_ready) got_q.push_back(o_z);
            if (i_valid && o_ready) idx++;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        chk("bp_count", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_order", 64'(got_q[i]), 64'(bp_e[i]));

        // Reset with two results in flight.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_a = 8'd11; i_b = 8'd13; i_mode = 2'b00;
        @(posedge i_clk); #1;
        i_a = 8'd17; i_b = 8'd19;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(negedge i_clk);
        chk("rst_pre_full", 64'({o_valid, o_ready}), 64'({1'b1, 1'b0}));
        #2 i_rst_n = 1'b0;
        #1 chk("rst_async", 64'({o_valid, o_approx, o_z}), 64'(0));
        @(posedge i_clk); #2;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("rst_no_stale", 64'(o_valid), 64'(0));
        @(posedge i_clk); #1;
        single("rst_fresh", 8'd2, 8'd3, 2'b00, 16'd6, 1'b0);

        // Random stream with random valid/ready across all modes.
        sb_en = 1'b1;
        for (int cyc = 0; cyc < 60000 && (n_acc < 10000 || sb_q.size() != 0); cyc++) begin
            i_valid = (n_acc < 10000) && ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 9) < 7);
            i_a     = W'($urandom);
            i_b     = W'($urandom);
            i_mode  = 2'($urandom_range(0, 3));
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        sb_en   = 1'b0;
        chk("rand_accepted", 64'(n_acc), 64'(10000));
        chk("rand_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hlr_bm_pipe.md
Name: hlr_bm_pipe

Overview:
- Parametrised, pipelined successor to the fixed 8x8 hybrid low-radix Booth multiplier (HLR BM family).
- LSB slice of the multiplier is radix-8 encoded, with selectable approximation of the ±3C digits. The remaining MSB slice is exact radix-4.
- Adds a valid/ready stream interface, a 2-stage pipeline with backpressure, a runtime approximation-mode select and an approximation flag.
- Sits in the approximate-arithmetic test bench datapath between the operand source and the error-statistics collector.

Parameters:
- WIDTH, 8, operand width in bits (signed, two's complement); WIDTH >= 4.
- N_R8, 2, number of radix-8 groups in the LSBs; (WIDTH - 3*N_R8) must be even and >= 0. Elaboration error otherwise.
- N_R4, (WIDTH-3*N_R8)/2, derived; number of exact radix-4 groups in the MSBs.

Ports:
- i_clk, input, 1, clock; all state updates on the rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_valid, input, 1, input operands valid.
- o_ready, output, 1, block can accept input this cycle.
- i_a, input, WIDTH, signed multiplier (Booth-encoded operand).
- i_b, input, WIDTH, signed multiplicand.
- i_mode, input, 2, 00 = EXACT, 01 = R8ABE1, 10 = R8ABE2, 11 = reserved (treated as EXACT).
- o_valid, output, 1, result valid.
- i_ready, input, 1, downstream accepts result.
- o_z, output, 2*WIDTH, signed product (mode-dependent).
- o_approx, output, 1, result used at least one approximated digit.

Behaviour:
- Reset: all pipeline valids clear; o_valid = 0, o_z = 0, o_approx = 0. Data registers reset to 0. Reset is asynchronous assert, clock-synchronous release.
- Encoding:
  - x = {i_a, 1'b0}.
  - R8 group k (k = 0..N_R8-1) = x[3k+3:3k], weight 8^k.
  - R4 group j = x[3*N_R8+2j+2 : 3*N_R8+2j], weight 2^(3*N_R8+2j).
  - Each group overlaps the previous group by one bit.
- R8 digits: 0000/1111 = 0; 0001/0010 = +1C; 0011/0100 = +2C; 0111 = +4C; 1000 = -4C; 1011/1100 = -2C; 1101/1110 = -1C.
- ±3C codes (0101, 0110 = +3; 1001, 1010 = -3):
  - EXACT: ±3C computed exactly as ±(2C + C).
  - R8ABE1: all four codes become ±4C (sign preserved).
  - R8ABE2: 0101 -> +2C, 0110 -> +4C, 1010 -> -2C, 1001 -> -4C.
- R4 digits: standard exact radix-4 Booth (0, ±1C, ±2C).
- Arithmetic: each partial product is sign-extended to 2*WIDTH+1 bits and shifted by its weight. The sum is taken modulo 2^(2*WIDTH+1); o_z = sum[2*WIDTH-1:0]. In EXACT mode o_z == i_a*i_b for all inputs.
- o_approx = 1 iff mode is R8ABE1/R8ABE2 and at least one R8 group holds a ±3 code.
- Pipeline:
  - S1 registers i_a, i_b and the effective mode on handshake (i_valid & o_ready).
  - S2 registers o_z and o_approx from the S1 contents.
  - Latency is exactly 2 cycles from accept to o_valid when i_ready is held high. Throughput is 1 per cycle.
- Handshake:
  - adv2 = ~v2 | i_ready; adv1 = ~v1 | adv2; o_ready = adv1. The combinational ready path is permitted.
  - Stage registers hold while not advancing.
  - o_z and o_approx are stable while o_valid & ~i_ready.
  - A result is consumed on o_valid & i_ready.
  - Simultaneous consume and accept in the same cycle sustains full throughput.
  - i_mode is sampled only on accept; mode changes mid-stream affect only later operands.
- Boundaries:
  - Full pipeline with i_ready = 0: o_ready = 0 and no data is lost or duplicated.
  - Reset asserted mid-operation: in-flight results are discarded and o_valid drops immediately (asynchronously).

Decomposition:
- Package hlr_pkg:
  - hlr_mode_e enum (MODE_EXACT, MODE_ABE1, MODE_ABE2).
  - Digit constants.
  - Function r8_digit(code, mode), returning signed digit -4..+4 plus an approx bit.
  - Function r4_digit(code).
- Sub-module hlr_pp_gen: a combinational partial-product generator, parametrised by WIDTH and N_R8. Inputs are x, b and mode; outputs are the summed product and o_approx. It is instantiated between S1 and S2.

Test Plan:
- EXACT, WIDTH=8, a=-128, b=-128 -> o_z=16384, o_approx=0; a=5, b=10 -> 50, o_approx=0. Both results arrive exactly 2 cycles after accept.
- Mode R8ABE2: a=5, b=10 -> 60, o_approx=1; a=3, b=7 -> 28, o_approx=1; a=-1, b=9 -> -9, o_approx=0.
- Mode R8ABE1: a=5, b=10 -> 40, o_approx=1; a=3, b=7 -> 28, o_approx=1.
- Backpressure: stream 4 operands back-to-back with i_ready=0 for 5 cycles.
  - o_ready must fall after 2 accepts.
  - o_z must hold while stalled.
  - After i_ready=1, results must emerge in order with no loss or duplication.
- Reset with 2 results in flight: o_valid=0 immediately. After release, a fresh a=2, b=3 (EXACT) yields 6 with no stale output.
- Random 10k vectors across all modes, checked against a reference-model scoreboard. EXACT must have zero error; R8ABE1/R8ABE2 results must match the digit-table model bit-exactly.
